// File: rtl/pair_match_pkg.sv
// pair_match_pkg: shared types and constants for the pair match monitor
package pair_match_pkg;
  localparam int DEF_WIDTH = 16;
  typedef enum logic [1:0] {T_IDLE, T_LAST_MATCH, T_LAST_MISS} pair_track_e;
  typedef struct packed {
    logic                 match;
    logic [DEF_WIDTH-1:0] diff;
  } pair_res_t;
endpackage

// File: rtl/pair_res_fifo.sv
// pair_res_fifo: two-entry result FIFO with asynchronous active-low reset
module pair_res_fifo #(
  parameter int W = 17
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wp, rp;
  logic [1:0]   cnt;
  assign full  = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  assign dout  = mem[rp];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= !wp;
      end
      if (pop) rp <= !rp;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/pair_match_monitor.sv
// pair_match_monitor: classifies word pairs, buffers results and tracks the match toggle rule
module pair_match_monitor
  import pair_match_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_match,
  output logic [WIDTH-1:0] out_diff,
  input  logic             clear,
  output logic             viol,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  bit   [WIDTH-1:0] a2, b2;
  logic             match, accept, pop, full, empty, rdy_q, viol_set;
  logic [WIDTH:0]   head;
  logic [CNT_W-1:0] m_base, x_base;
  pair_track_e      state, state_nx;
  assign a2        = in_a;
  assign b2        = in_b;
  assign match     = a2 == b2;
  assign out_valid = !empty;
  assign pop       = out_valid & out_ready;
  assign in_ready  = rdy_q & (!full | out_ready);
  assign accept    = in_valid & in_ready;
  assign out_match = head[WIDTH];
  assign out_diff  = head[WIDTH-1:0];
  assign m_base    = clear ? '0 : match_cnt;
  assign x_base    = clear ? '0 : miss_cnt;
  pair_res_fifo #(.W(WIDTH + 1)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (accept),
    .pop     (pop),
    .din     ({match, a2 ^ b2}),
    .dout    (head),
    .full    (full),
    .empty   (empty)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= T_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = clear ? T_IDLE : state;
    viol_set = 1'b0;
    if (accept) begin
      state_nx = match ? T_LAST_MATCH : T_LAST_MISS;
      viol_set = match & !clear & (state == T_LAST_MATCH);
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q     <= 1'b0;
      viol      <= 1'b0;
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      rdy_q     <= 1'b1;
      viol      <= (viol & !clear) | viol_set;
      match_cnt <= m_base + CNT_W'(accept & match & (m_base != CNT_MAX));
      miss_cnt  <= x_base + CNT_W'(accept & !match & (x_base != CNT_MAX));
    end
  end
endmodule

// File: tb/tb_pair_match_monitor.sv
// tb_pair_match_monitor: directed self-checking bench for pair_match_monitor
module tb_pair_match_monitor;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_match;
  logic [15:0] out_diff;
  logic        clear = 1'b0;
  logic        viol;
  logic [1:0]  match_cnt, miss_cnt;
  int          total = 0;
  int          bad = 0;
  pair_match_monitor #(.WIDTH(16), .CNT_W(2)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_match (out_match),
    .out_diff  (out_diff),
    .clear     (clear),
    .viol      (viol),
    .match_cnt (match_cnt),
    .miss_cnt  (miss_cnt)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b);
    in_valid = v;
    in_a     = a;
    in_b     = b;
  endtask
  task automatic chk_out(input string tag, input logic v, input logic m, input logic [15:0] d);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_match"}, 32'(out_match), 32'(m));
    chk({tag, "_diff"}, 32'(out_diff), 32'(d));
  endtask
  task automatic chk_stat(input string tag, input logic v, input logic [1:0] mc, input logic [1:0] xc);
    chk({tag, "_viol"}, 32'(viol), 32'(v));
    chk({tag, "_mcnt"}, 32'(match_cnt), 32'(mc));
    chk({tag, "_xcnt"}, 32'(miss_cnt), 32'(xc));
  endtask
  initial begin
    #2 reset_n = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk_out("rst", 1'b0, 1'b0, 16'h0);
    chk_stat("rst", 1'b0, 2'd0, 2'd0);
    reset_n = 1'b1;
    #1 chk("rel_ready_early", 32'(in_ready), 32'd0);
    tick();
    chk("rel_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    drive(1'b1, 16'h1234, 16'h1234);
    tick();
    chk_out("alt0", 1'b1, 1'b1, 16'h0000);
    drive(1'b1, 16'h1234, 16'h1235);
    tick();
    chk_out("alt1", 1'b1, 1'b0, 16'h0001);
    drive(1'b1, 16'hFFFF, 16'hFFFF);
    tick();
    chk_out("alt2", 1'b1, 1'b1, 16'h0000);
    drive(1'b0, 16'h0, 16'h0);
    tick();
    chk("alt_drain", 32'(out_valid), 32'd0);
    chk_stat("alt", 1'b0, 2'd2, 2'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_stat("clr1", 1'b0, 2'd0, 2'd0);
    drive(1'b1, 16'hA5A5, 16'hA5A5);
    tick();
    chk("dbl_first", 32'(viol), 32'd0);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    chk_stat("dbl_second", 1'b1, 2'd2, 2'd0);
    tick();
    chk("dbl_sticky", 32'(viol), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_stat("clr2", 1'b0, 2'd0, 2'd0);
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 16'h0001);
    tick();
    chk_out("bp_p1", 1'b1, 1'b1, 16'h0000);
    drive(1'b1, 16'h0002, 16'h0003);
    #1 chk("bp_rdy1", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 16'h0004, 16'h0004);
    #1 chk("bp_full", 32'(in_ready), 32'd0);
    chk_out("bp_hold0", 1'b1, 1'b1, 16'h0000);
    tick();
    chk_out("bp_hold1", 1'b1, 1'b1, 16'h0000);
    chk("bp_still_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1 chk("bp_pushpop_rdy", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    chk_out("bp_p2", 1'b1, 1'b0, 16'h0001);
    tick();
    chk_out("bp_p3", 1'b1, 1'b1, 16'h0000);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk_stat("bp", 1'b0, 2'd2, 2'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h0000, 16'h0100);
      tick();
      drive(1'b1, 16'(i + 16), 16'(i + 16));
      tick();
      if (i == 2) chk_stat("sat_mid", 1'b0, 2'd3, 2'd3);
    end
    drive(1'b0, 16'h0, 16'h0);
    chk_stat("sat", 1'b0, 2'd3, 2'd3);
    clear = 1'b1;
    drive(1'b1, 16'h0007, 16'h0007);
    tick();
    clear = 1'b0;
    chk_stat("clr_acc", 1'b0, 2'd1, 2'd0);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    chk_stat("clr_acc_track", 1'b1, 2'd2, 2'd0);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 16'h00F0, 16'h000F);
    tick();
    drive(1'b1, 16'h0F00, 16'h0000);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    chk("mr_full", 32'(in_ready), 32'd0);
    chk_out("mr_head", 1'b1, 1'b0, 16'h00FF);
    reset_n = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_ready", 32'(in_ready), 32'd0);
    chk_stat("mr", 1'b0, 2'd0, 2'd0);
    tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_stale", 32'(out_valid), 32'd0);
    end
    drive(1'b1, 16'h5555, 16'h5555);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    chk_out("mr_new", 1'b1, 1'b1, 16'h0000);
    chk_stat("mr_new", 1'b0, 2'd1, 2'd0);
    tick();
    chk("mr_new_drain", 32'(out_valid), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
